// File: rtl/ixc_readback_9.sv
// ixc_readback_9: snapshots a WIDTH-bit net on req and streams it out LSB first, one bit per valid/ready handshake; define IXC_READBACK_PARITY_EN to append an even-parity bit
module ixc_readback_9 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] R,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] snap,
  output logic             sdo,
  output logic             sdo_valid,
  input  logic             sdo_ready,
  output logic             sdo_last,
  output logic             done,
  output logic             ovf
);
`ifdef IXC_READBACK_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int IW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t         state, state_nx;
  logic [IW-1:0]  idx;
  logic [WIDTH-1:0] sh;
  logic           fire, at_last, cur_bit;
  // next state and outputs decoded from registered state only; sdo_ready feeds only next-state
  always_comb begin
    at_last = idx == IW'(LAST);
    fire = (state == SHIFT) && sdo_ready;
    state_nx = (state == IDLE) ? (req ? SHIFT : IDLE) : ((fire && at_last) ? IDLE : SHIFT);
    sh = snap >> idx;
`ifdef IXC_READBACK_PARITY_EN
    cur_bit = at_last ? ^snap : sh[0];
`else
    cur_bit = sh[0];
`endif
    busy = state == SHIFT;
    sdo_valid = busy;
    sdo = busy & cur_bit;
    sdo_last = busy & at_last;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // capture, bit index, done pulse and sticky overflow; reset aborts any frame without done
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      idx <= '0;
      ovf <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fire && at_last;
      if (state == IDLE && req) begin
        snap <= R;
        idx <= '0;
        ovf <= 1'b0;
      end
      if (state == SHIFT && req) ovf <= 1'b1;
      if (fire && !at_last) idx <= idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_ixc_readback_9.sv
// tb_ixc_readback_9: scoreboard bench streaming frames through ixc_readback_9
module tb_ixc_readback_9;
  localparam int WIDTH = 9;
`ifdef IXC_READBACK_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  typedef struct packed {logic b; logic l;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH-1:0] R = '0;
  logic req = 1'b0;
  logic sdo_ready = 1'b1;
  logic busy, sdo, sdo_valid, sdo_last, done, ovf;
  logic [WIDTH-1:0] snap;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  ixc_readback_9 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .R(R), .req(req), .busy(busy), .snap(snap),
    .sdo(sdo), .sdo_valid(sdo_valid), .sdo_ready(sdo_ready),
    .sdo_last(sdo_last), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // scoreboard: every accepted bit is popped and compared
  always @(negedge clk) begin
    if (!rst && sdo_valid && sdo_ready) begin
      exp_t e;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_bit sdo=%0b sdo_last=%0b required none", sdo, sdo_last);
      end else begin
        e = q.pop_front();
        if (sdo !== e.b || sdo_last !== e.l) begin
          fails++;
          $display("FAIL stream_bit sdo=%0b last=%0b required %0b/%0b", sdo, sdo_last, e.b, e.l);
        end
      end
    end
  end

  task automatic push_bits(input logic [WIDTH-1:0] val, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = (i < WIDTH) ? val[i] : ^val;
      e.l = (i == FRAME - 1);
      q.push_back(e);
    end
  endtask

  task automatic start(input logic [WIDTH-1:0] val);
    @(posedge clk); #1;
    R = val;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout cycles=%0d required <200", n);
    end
  endtask

  task automatic check_empty(input string name);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s leftover_bits=%0d required 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, snap, sdo, sdo_valid, sdo_last, done, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs busy=%0b snap=%h sdo=%0b v=%0b l=%0b done=%0b ovf=%0b required all 0",
               busy, snap, sdo, sdo_valid, sdo_last, done, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    start(9'h1A5);
    push_bits(9'h1A5, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      tests++;
      if (sdo_valid !== 1'b1 || busy !== 1'b1 || sdo_last !== (i == FRAME - 1) || done !== 1'b0) begin
        fails++;
        $display("FAIL basic_cycle%0d v=%0b busy=%0b last=%0b done=%0b required 1/1/%0b/0",
                 i, sdo_valid, busy, sdo_last, done, i == FRAME - 1);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || sdo_valid !== 1'b0 || busy !== 1'b0 || snap !== 9'h1A5) begin
      fails++;
      $display("FAIL basic_done done=%0b v=%0b busy=%0b snap=%h required 1/0/0/1a5", done, sdo_valid, busy, snap);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse done=%0b required 0", done);
    end
    check_empty("basic_count");
  endtask

  task automatic test_stall;
    logic [3:0] pat = 4'b1001;
    logic hv = 1'b0;
    logic ps, pl;
    int k = 0;
    start(9'h0FF);
    push_bits(9'h0FF, FRAME);
    while (!done && k < 200) begin
      sdo_ready = pat[k % 4];
      if (k == 3) R = '0;
      @(negedge clk);
      if (hv) begin
        tests++;
        if (sdo_valid !== 1'b1 || sdo !== ps || sdo_last !== pl) begin
          fails++;
          $display("FAIL stall_hold v=%0b sdo=%0b last=%0b required 1/%0b/%0b", sdo_valid, sdo, sdo_last, ps, pl);
        end
      end
      hv = sdo_valid && !sdo_ready;
      ps = sdo;
      pl = sdo_last;
      k++;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    tests++;
    if (!done || snap !== 9'h0FF) begin
      fails++;
      $display("FAIL stall_end done=%0b snap=%h required 1/0ff", done, snap);
    end
    sdo_ready = 1'b1;
    check_empty("stall_count");
  endtask

  task automatic test_ovf;
    int n;
    start(9'h133);
    push_bits(9'h133, FRAME);
    repeat (3) begin
      @(posedge clk); #1;
    end
    req = 1'b1;
    @(negedge clk);
    tests++;
    if (ovf !== 1'b0 || sdo_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovf_before ovf=%0b v=%0b required 0/1", ovf, sdo_valid);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    tests++;
    if (ovf !== 1'b1 || snap !== 9'h133) begin
      fails++;
      $display("FAIL ovf_set ovf=%0b snap=%h required 1/133", ovf, snap);
    end
    wait_done(n);
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky ovf=%0b required 1", ovf);
    end
    check_empty("ovf_frame");
    start(9'h04B);
    push_bits(9'h04B, FRAME);
    @(negedge clk);
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear ovf=%0b required 0", ovf);
    end
    wait_done(n);
    check_empty("ovf_next");
  endtask

  task automatic test_back_to_back;
    int n;
    @(posedge clk); #1;
    R = 9'h155;
    req = 1'b1;
    @(posedge clk); #1;
    R = 9'h0AA;
    push_bits(9'h155, FRAME);
    push_bits(9'h0AA, FRAME);
    wait_done(n);
    tests++;
    if (n != FRAME + 1 || sdo_valid !== 1'b0 || ovf !== 1'b1 || snap !== 9'h155) begin
      fails++;
      $display("FAIL b2b_first cycles=%0d v=%0b ovf=%0b snap=%h required %0d/0/1/155", n, sdo_valid, ovf, snap, FRAME + 1);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    tests++;
    if (sdo_valid !== 1'b1 || ovf !== 1'b0 || snap !== 9'h0AA || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_recapture v=%0b ovf=%0b snap=%h done=%0b required 1/0/0aa/0", sdo_valid, ovf, snap, done);
    end
    wait_done(n);
    tests++;
    if (n != FRAME || snap !== 9'h0AA) begin
      fails++;
      $display("FAIL b2b_second cycles=%0d snap=%h required %0d/0aa", n + 1, snap, FRAME + 1);
    end
    check_empty("b2b_count");
  endtask

  task automatic test_abort;
    int n;
    int dcnt = 0;
    start(9'h1C7);
    push_bits(9'h1C7, 5);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (sdo_valid !== 1'b0 || busy !== 1'b0 || snap !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_state v=%0b busy=%0b snap=%h done=%0b required 0/0/000/0", sdo_valid, busy, snap, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests++;
    if (dcnt != 0) begin
      fails++;
      $display("FAIL abort_no_done pulses=%0d required 0", dcnt);
    end
    check_empty("abort_count");
    start(9'h0E1);
    push_bits(9'h0E1, FRAME);
    @(negedge clk);
    tests++;
    if (sdo_valid !== 1'b1 || sdo !== 1'b1 || snap !== 9'h0E1) begin
      fails++;
      $display("FAIL abort_restart v=%0b sdo=%0b snap=%h required 1/1/0e1", sdo_valid, sdo, snap);
    end
    wait_done(n);
    tests++;
    if (n != FRAME) begin
      fails++;
      $display("FAIL abort_restart_len cycles=%0d required %0d", n + 1, FRAME + 1);
    end
    check_empty("abort_restart_count");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ovf();
    test_back_to_back();
    test_abort();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
